alarm_delay_sequencer: RTL and testbench
========================================

Name: alarm_delay_sequencer

Overview:
- Top-level alarm state machine that owns and sequences a 9-bit loadable up-counter with a terminal-count flag.
- Implements the arm/exit-delay, entry-delay and siren phases.
- Issues master-reset, enable and load strobes to the counter, detects expiry from the counter's Tc flag, and drives the siren, armed indicator and a seconds-remaining display value.

Parameters:
- WIDTH, 9, counter width; must match the sequenced counter.
- EXIT_DELAY, 30, ticks from arm to ARMED; legal range 1..2**WIDTH-1.
- ENTRY_DELAY, 20, ticks from sensor trip to ALARM; legal range 1..2**WIDTH-1.
- SIREN_TIME, 300, siren duration in ticks; used only with SIREN_TIMEOUT_EN.

Ports:
- clock50  in  1  system clock, 50 MHz, all logic on its rising edge.
- Mr_n  in  1  master reset; synchronous, active-low.
- tick_1hz  in  1  one-cycle pulse, 1 Hz; the timing base.
- arm  in  1  arm request (level sampled each cycle).
- disarm  in  1  valid-code disarm request.
- sensor  in  1  door/PIR trip, level.
- panic  in  1  panic button.
- cnt_qout  in  WIDTH  counter value.
- cnt_tc  in  1  counter terminal-count flag.
- cnt_mr  out  1  counter master reset (active-high).
- cnt_en  out  1  counter enable.
- cnt_load_en  out  1  counter load strobe.
- cnt_load_value  out  WIDTH  counter load value.
- state_o  out  3  current state encoding.
- siren  out  1  siren drive.
- armed_led  out  1  high in EXIT, ARMED, ENTRY.
- secs_left  out  WIDTH  remaining ticks of the active delay, else 0.

Behaviour:
- Counter semantics relied on:
  - Mr clears the value but not Tc.
  - Load does not clear Tc.
  - Tc sets on wrap 2**WIDTH-1 -> 0.
  - Tc clears only when counting with En from value 0.
- Reset (Mr_n low at clock edge): state DISARMED; all outputs 0; tc_q 0; target 0.
- States: DISARMED=0, PRIME=1, EXIT=2, ARMED=3, ENTRY=4, ALARM=5; 6 and 7 recover to DISARMED.
- PRIME is a 3-cycle sequence driven by a 2-bit phase counter, with a registered target (EXIT, ENTRY or ALARM-timed):
  - phase0: cnt_mr=1.
  - phase1: cnt_en=1, which clears Tc and makes the counter 1.
  - phase2: cnt_load_en=1, cnt_load_value = 2**WIDTH - D (D = delay of target); next state = target.
- tick_1hz is ignored during PRIME.
- Timed states:
  - cnt_en = tick_1hz.
  - tc_q registers cnt_tc every cycle.
  - Expiry = cnt_tc & ~tc_q, i.e. exactly D ticks after the load.
  - secs_left = 2**WIDTH - cnt_qout when cnt_qout != 0, else 0.
- Transitions, in priority order:
  - panic from any state -> ALARM, immediate; panic beats disarm in the same cycle.
  - disarm from any state except panic -> DISARMED; any timing in progress is aborted and counter strobes go to 0 the next cycle.
  - DISARMED + arm -> PRIME(EXIT).
  - EXIT expiry -> ARMED; sensor ignored during EXIT.
  - ARMED + sensor -> PRIME(ENTRY).
  - ENTRY expiry -> ALARM.
  - arm outside DISARMED is ignored.
- Outputs: siren=1 only in ALARM; armed_led as listed in Ports.
- Strobes are registered, one cycle after the decision; cnt_en, cnt_mr and cnt_load_en are never asserted simultaneously.
- Mid-operation reset: everything returns to reset values on the next edge; the counter is re-primed on the next arm.

Optional Feature:
- SIREN_TIMEOUT_EN defined:
  - Entry to ALARM goes via PRIME(ALARM) with D=SIREN_TIME; siren is on during this PRIME.
  - On expiry -> ARMED with siren off.
  - panic during a timed ALARM re-primes the timeout.
- Not defined: ALARM holds the siren until disarm; the counter is idle (no strobes).

Decomposition:
- Shared package alarm_pkg: state enum (3-bit encodings above), prime phase constants, and a function computing the load value 2**WIDTH - D.
- One natural sub-module: alarm_prime_seq, the 3-phase counter prime/load sequencer with done and expiry-edge outputs.

Test Plan:
- Reset, then arm with EXIT_DELAY=30: expect cnt_mr, cnt_en, cnt_load_en on consecutive cycles; load value 482; state EXIT; ARMED 1 cycle after the 30th tick edge.
- In ARMED, pulse sensor: ENTRY load value 492; secs_left 20 -> 1 stepping per tick; ALARM and siren=1 after tick 20.
- In ENTRY with secs_left=7, assert disarm: next state DISARMED, siren 0, cnt_en stays 0 on later ticks.
- Assert panic and disarm in the same cycle from ARMED: state ALARM, siren=1.
- Run exit, then entry back-to-back with Tc left high from the previous expiry: the second expiry still fires at exactly 20 ticks (prime clears Tc).
- With SIREN_TIMEOUT_EN and SIREN_TIME=3: siren drops and state becomes ARMED after the 3rd tick; without the macro, siren is held over 600 ticks until disarm.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding, prime phase constants and the counter
// load-value helper used by the alarm delay sequencer.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_PRIME    = 3'd1,
    ST_EXIT     = 3'd2,
    ST_ARMED    = 3'd3,
    ST_ENTRY    = 3'd4,
    ST_ALARM    = 3'd5
  } state_e;

  localparam logic [1:0] PH_MR   = 2'd0;
  localparam logic [1:0] PH_EN   = 2'd1;
  localparam logic [1:0] PH_LOAD = 2'd2;

  // Value to load into an up-counter so it wraps to 0 after exactly 'delay' counts.
  function automatic logic [31:0] load_for(input int unsigned width, input int unsigned delay);
    return (32'd1 << width) - delay;
  endfunction

endpackage

// File: rtl/alarm_delay_sequencer_prime.sv
// alarm_prime_seq: drives the external counter's mr/en/load strobes through the
// three-phase prime (clear, count-once to drop Tc, load), passes timed-state
// count enables through, and edge-detects the counter's terminal count.
module alarm_prime_seq
  import alarm_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clock50,
  input  logic             Mr_n,
  input  logic             in_prime,
  input  logic             prime_req,
  input  logic             restart,
  input  logic             count_en,
  input  logic [WIDTH-1:0] load_value,
  input  logic             cnt_tc,
  output logic             cnt_mr,
  output logic             cnt_en,
  output logic             cnt_load_en,
  output logic [WIDTH-1:0] cnt_load_value,
  output logic             done,
  output logic             expiry
);

  logic [1:0]       phase_q, phase_d;
  logic             mr_q, mr_d;
  logic             en_q, en_d;
  logic             ld_q, ld_d;
  logic [WIDTH-1:0] lv_q, lv_d;
  logic             tc_q, tc_d;

  // Next phase and strobes; strobes follow the phase being entered so they line up with it.
  always_comb begin
    phase_d = PH_MR;
    if (prime_req && in_prime && !restart) begin
      phase_d = phase_q + 2'd1;
    end
    mr_d = prime_req && (phase_d == PH_MR);
    en_d = (prime_req && (phase_d == PH_EN)) || count_en;
    ld_d = prime_req && (phase_d == PH_LOAD);
    lv_d = ld_d ? load_value : '0;
    tc_d = cnt_tc;
  end

  // Register phase, strobes and the Tc history.
  always_ff @(posedge clock50) begin
    if (!Mr_n) begin
      phase_q <= PH_MR;
      mr_q    <= 1'b0;
      en_q    <= 1'b0;
      ld_q    <= 1'b0;
      lv_q    <= '0;
      tc_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      mr_q    <= mr_d;
      en_q    <= en_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      tc_q    <= tc_d;
    end
  end

  assign cnt_mr         = mr_q;
  assign cnt_en         = en_q;
  assign cnt_load_en    = ld_q;
  assign cnt_load_value = lv_q;
  assign done           = in_prime && (phase_q == PH_LOAD);
  assign expiry         = cnt_tc && !tc_q;

endmodule

// File: rtl/alarm_delay_sequencer.sv
// alarm_delay_sequencer: alarm FSM sequencing an external 9-bit up-counter for
// exit, entry and (optionally) siren delays.
// Build option SIREN_TIMEOUT_EN: ALARM becomes a timed state of SIREN_TIME ticks
// that falls back to ARMED; without it ALARM holds the siren until disarm.
//
// state    | meaning
// DISARMED | idle, waiting for arm
// PRIME    | 3-cycle counter clear / Tc drop / load toward target_q
// EXIT     | exit delay running, sensor ignored
// ARMED    | watching sensor
// ENTRY    | entry delay running, disarm expected
// ALARM    | siren on
module alarm_delay_sequencer
  import alarm_pkg::*;
#(
  parameter int WIDTH       = 9,
  parameter int EXIT_DELAY  = 30,
  parameter int ENTRY_DELAY = 20,
  parameter int SIREN_TIME  = 300
) (
  input  logic             clock50,
  input  logic             Mr_n,
  input  logic             tick_1hz,
  input  logic             arm,
  input  logic             disarm,
  input  logic             sensor,
  input  logic             panic,
  input  logic [WIDTH-1:0] cnt_qout,
  input  logic             cnt_tc,
  output logic             cnt_mr,
  output logic             cnt_en,
  output logic             cnt_load_en,
  output logic [WIDTH-1:0] cnt_load_value,
  output logic [2:0]       state_o,
  output logic             siren,
  output logic             armed_led,
  output logic [WIDTH-1:0] secs_left
);

  localparam logic [WIDTH-1:0] LV_EXIT  = WIDTH'(load_for(WIDTH, EXIT_DELAY));
  localparam logic [WIDTH-1:0] LV_ENTRY = WIDTH'(load_for(WIDTH, ENTRY_DELAY));
  localparam logic [WIDTH-1:0] LV_SIREN = WIDTH'(load_for(WIDTH, SIREN_TIME));

  state_e           state_q, state_d;
  state_e           target_q, target_d;
  logic             siren_q, siren_d;
  logic             led_q, led_d;
  logic             restart;
  logic             timed_q;
  logic             count_en;
  logic             done;
  logic             expiry;
  logic [WIDTH-1:0] load_value;

  // Which states let ticks advance the counter.
  always_comb begin
    timed_q = (state_q == ST_EXIT) || (state_q == ST_ENTRY);
`ifdef SIREN_TIMEOUT_EN
    if (state_q == ST_ALARM) timed_q = 1'b1;
`endif
  end

  // Next-state decision: panic, then disarm, then per-state progress.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    restart  = 1'b0;
    if (panic) begin
`ifdef SIREN_TIMEOUT_EN
      state_d  = ST_PRIME;
      target_d = ST_ALARM;
      restart  = 1'b1;
`else
      state_d  = ST_ALARM;
`endif
    end else if (disarm) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED: if (arm) begin
          state_d  = ST_PRIME;
          target_d = ST_EXIT;
        end
        ST_PRIME:    if (done) state_d = target_q;
        ST_EXIT:     if (expiry) state_d = ST_ARMED;
        ST_ARMED:    if (sensor) begin
          state_d  = ST_PRIME;
          target_d = ST_ENTRY;
        end
        ST_ENTRY:    if (expiry) begin
`ifdef SIREN_TIMEOUT_EN
          state_d  = ST_PRIME;
          target_d = ST_ALARM;
`else
          state_d  = ST_ALARM;
`endif
        end
        ST_ALARM: begin
`ifdef SIREN_TIMEOUT_EN
          if (expiry) state_d = ST_ARMED;
`endif
        end
        default:     state_d = ST_DISARMED;
      endcase
    end
  end

  // Output decode from the state being entered, plus counter load value and tick gating.
  always_comb begin
    siren_d  = (state_d == ST_ALARM) || ((state_d == ST_PRIME) && (target_d == ST_ALARM));
    led_d    = (state_d == ST_EXIT) || (state_d == ST_ARMED) || (state_d == ST_ENTRY);
    count_en = tick_1hz && timed_q && (state_d == state_q);
    case (target_q)
      ST_EXIT:  load_value = LV_EXIT;
      ST_ENTRY: load_value = LV_ENTRY;
      ST_ALARM: load_value = LV_SIREN;
      default:  load_value = '0;
    endcase
  end

  // FSM state, prime target and registered indicator outputs.
  always_ff @(posedge clock50) begin
    if (!Mr_n) begin
      state_q  <= ST_DISARMED;
      target_q <= ST_DISARMED;
      siren_q  <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      siren_q  <= siren_d;
      led_q    <= led_d;
    end
  end

  alarm_prime_seq #(.WIDTH(WIDTH)) u_prime (
    .clock50        (clock50),
    .Mr_n           (Mr_n),
    .in_prime       (state_q == ST_PRIME),
    .prime_req      (state_d == ST_PRIME),
    .restart        (restart),
    .count_en       (count_en),
    .load_value     (load_value),
    .cnt_tc         (cnt_tc),
    .cnt_mr         (cnt_mr),
    .cnt_en         (cnt_en),
    .cnt_load_en    (cnt_load_en),
    .cnt_load_value (cnt_load_value),
    .done           (done),
    .expiry         (expiry)
  );

  // Remaining ticks: 2**WIDTH - count, which is zero when the count is zero.
  assign secs_left = timed_q ? ('0 - cnt_qout) : '0;
  assign state_o   = state_q;
  assign siren     = siren_q;
  assign armed_led = led_q;

endmodule

// File: tb/tb_alarm_delay_sequencer.sv
// Directed bench for alarm_delay_sequencer with a behavioural 9-bit up-counter
// attached. Honours SIREN_TIMEOUT_EN (siren time overridden to 3 ticks).
module tb_alarm_delay_sequencer;

  logic       clock50 = 1'b0;
  logic       Mr_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       arm = 1'b0;
  logic       disarm = 1'b0;
  logic       sensor = 1'b0;
  logic       panic = 1'b0;
  logic [8:0] cnt_qout;
  logic       cnt_tc;
  logic       cnt_mr, cnt_en, cnt_load_en;
  logic [8:0] cnt_load_value;
  logic [2:0] state_o;
  logic       siren, armed_led;
  logic [8:0] secs_left;

  int n_tests = 0;
  int n_fail  = 0;
  int en_seen = 0;
  int overlap = 0;
  int snap;

  alarm_delay_sequencer #(.WIDTH(9), .EXIT_DELAY(30), .ENTRY_DELAY(20), .SIREN_TIME(3)) dut (
    .clock50        (clock50),
    .Mr_n           (Mr_n),
    .tick_1hz       (tick_1hz),
    .arm            (arm),
    .disarm         (disarm),
    .sensor         (sensor),
    .panic          (panic),
    .cnt_qout       (cnt_qout),
    .cnt_tc         (cnt_tc),
    .cnt_mr         (cnt_mr),
    .cnt_en         (cnt_en),
    .cnt_load_en    (cnt_load_en),
    .cnt_load_value (cnt_load_value),
    .state_o        (state_o),
    .siren          (siren),
    .armed_led      (armed_led),
    .secs_left      (secs_left)
  );

  always #10 clock50 = ~clock50;

  // Counter model; Tc starts high to show that priming clears it.
  logic [8:0] m_q = 9'd0;
  logic       m_tc = 1'b1;
  assign cnt_qout = m_q;
  assign cnt_tc   = m_tc;
  always @(posedge clock50) begin
    if (cnt_mr) m_q <= 9'd0;
    else if (cnt_load_en) m_q <= cnt_load_value;
    else if (cnt_en) begin
      if (m_q == 9'd511) m_tc <= 1'b1;
      else if (m_q == 9'd0) m_tc <= 1'b0;
      m_q <= m_q + 9'd1;
    end
  end

  always @(negedge clock50) begin
    if (cnt_en) en_seen <= en_seen + 1;
    if ((32'(cnt_mr) + 32'(cnt_en) + 32'(cnt_load_en)) > 32'd1) overlap <= overlap + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  task automatic do_tick();
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    cyc(2);
  endtask

  task automatic run_exit();
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    cyc(3);
    repeat (30) do_tick();
  endtask

  initial begin
    // Reset
    cyc(2);
    chk("rst_state", 32'(state_o), 0);
    chk("rst_siren", 32'(siren), 0);
    chk("rst_led", 32'(armed_led), 0);
    chk("rst_mr", 32'(cnt_mr), 0);
    chk("rst_en", 32'(cnt_en), 0);
    chk("rst_ld", 32'(cnt_load_en), 0);
    chk("rst_lv", 32'(cnt_load_value), 0);
    chk("rst_secs", 32'(secs_left), 0);
    Mr_n = 1'b1;
    cyc(1);

    // Arm: prime strobes on consecutive cycles, then EXIT
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    chk("p0_state", 32'(state_o), 1);
    chk("p0_mr", 32'(cnt_mr), 1);
    chk("p0_en", 32'(cnt_en), 0);
    chk("p0_ld", 32'(cnt_load_en), 0);
    cyc(1);
    chk("p1_en", 32'(cnt_en), 1);
    chk("p1_mr", 32'(cnt_mr), 0);
    cyc(1);
    chk("p2_ld", 32'(cnt_load_en), 1);
    chk("p2_lv", 32'(cnt_load_value), 482);
    chk("p2_en", 32'(cnt_en), 0);
    cyc(1);
    chk("exit_state", 32'(state_o), 2);
    chk("exit_led", 32'(armed_led), 1);
    chk("exit_secs", 32'(secs_left), 30);
    chk("exit_ld", 32'(cnt_load_en), 0);
    for (int i = 1; i <= 29; i++) begin
      if (i == 10) sensor = 1'b1;
      do_tick();
      sensor = 1'b0;
    end
    chk("exit29_state", 32'(state_o), 2);
    chk("exit29_secs", 32'(secs_left), 1);
    tick_1hz = 1'b1;
    cyc(1);
    tick_1hz = 1'b0;
    chk("exit30_en", 32'(cnt_en), 1);
    chk("exit30_state", 32'(state_o), 2);
    cyc(1);
    chk("wrap_state", 32'(state_o), 2);
    chk("wrap_secs", 32'(secs_left), 0);
    cyc(1);
    chk("armed_state", 32'(state_o), 3);
    chk("armed_led", 32'(armed_led), 1);

    // Panic beats disarm
    panic = 1'b1;
    disarm = 1'b1;
    cyc(1);
    panic = 1'b0;
    disarm = 1'b0;
`ifdef SIREN_TIMEOUT_EN
    chk("panic_state", 32'(state_o), 1);
    chk("panic_siren", 32'(siren), 1);
    chk("panic_mr", 32'(cnt_mr), 1);
    cyc(3);
    chk("panic_alarm", 32'(state_o), 5);
    chk("panic_secs", 32'(secs_left), 3);
`else
    chk("panic_state", 32'(state_o), 5);
    chk("panic_en", 32'(cnt_en), 0);
`endif
    chk("panic_siren2", 32'(siren), 1);
    chk("panic_led", 32'(armed_led), 0);
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
    chk("dis1_state", 32'(state_o), 0);
    chk("dis1_siren", 32'(siren), 0);

    // Entry then disarm at secs_left=7
    run_exit();
    chk("re_armed", 32'(state_o), 3);
    chk("re_armed_secs", 32'(secs_left), 0);
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    chk("ep0_state", 32'(state_o), 1);
    chk("ep0_led", 32'(armed_led), 0);
    chk("ep0_mr", 32'(cnt_mr), 1);
    cyc(2);
    chk("ep2_ld", 32'(cnt_load_en), 1);
    chk("ep2_lv", 32'(cnt_load_value), 492);
    cyc(1);
    chk("entry_state", 32'(state_o), 4);
    chk("entry_secs", 32'(secs_left), 20);
    chk("entry_led", 32'(armed_led), 1);
    repeat (13) do_tick();
    chk("entry13_secs", 32'(secs_left), 7);
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
    chk("dis2_state", 32'(state_o), 0);
    chk("dis2_siren", 32'(siren), 0);
    chk("dis2_led", 32'(armed_led), 0);
    chk("dis2_secs", 32'(secs_left), 0);
    snap = en_seen;
    repeat (3) do_tick();
    chk("dis2_no_en", 32'(en_seen - snap), 0);

    // Exit then entry back-to-back, Tc high from the exit expiry
    run_exit();
    chk("b2b_armed", 32'(state_o), 3);
    sensor = 1'b1;
    cyc(1);
    sensor = 1'b0;
    cyc(3);
    chk("b2b_entry", 32'(state_o), 4);
    chk("b2b_secs", 32'(secs_left), 20);
    for (int i = 1; i <= 19; i++) begin
      do_tick();
      chk("b2b_step", 32'(secs_left), 32'(20 - i));
    end
    chk("b2b_still_entry", 32'(state_o), 4);
    do_tick();
`ifdef SIREN_TIMEOUT_EN
    chk("b2b_prime_alarm", 32'(state_o), 1);
    chk("b2b_siren", 32'(siren), 1);
    cyc(3);
    chk("to_alarm", 32'(state_o), 5);
    chk("to_secs", 32'(secs_left), 3);
    chk("to_siren", 32'(siren), 1);
    repeat (2) do_tick();
    chk("to_secs1", 32'(secs_left), 1);
    chk("to_still_alarm", 32'(state_o), 5);
    do_tick();
    chk("to_armed", 32'(state_o), 3);
    chk("to_siren_off", 32'(siren), 0);
    chk("to_led", 32'(armed_led), 1);
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
    chk("dis3_state", 32'(state_o), 0);
`else
    chk("b2b_alarm", 32'(state_o), 5);
    chk("b2b_siren", 32'(siren), 1);
    chk("b2b_led", 32'(armed_led), 0);
    chk("b2b_secs0", 32'(secs_left), 0);
    snap = en_seen;
    repeat (600) do_tick();
    chk("hold_no_en", 32'(en_seen - snap), 0);
    chk("hold_state", 32'(state_o), 5);
    chk("hold_siren", 32'(siren), 1);
    disarm = 1'b1;
    cyc(1);
    disarm = 1'b0;
    chk("dis3_state", 32'(state_o), 0);
    chk("dis3_siren", 32'(siren), 0);
`endif

    // Mid-operation reset, then re-arm re-primes the counter
    arm = 1'b1;
    cyc(1);
    arm = 1'b0;
    cyc(3);
    repeat (5) do_tick();
    chk("mid_secs", 32'(secs_left), 25);
    Mr_n = 1'b0;
    cyc(1);
    chk("mid_rst_state", 32'(state_o), 0);
    chk("mid_rst_led", 32'(armed_led), 0);
    chk("mid_rst_secs", 32'(secs_left), 0);
    chk("mid_rst_en", 32'(cnt_en), 0);
    chk("mid_rst_siren", 32'(siren), 0);
    Mr_n = 1'b1;
    cyc(1);
    run_exit();
    chk("rearm_armed", 32'(state_o), 3);

    chk("no_strobe_overlap", 32'(overlap), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
